// File: rtl/osd_frame_scanner.sv
// Raster-scan controller: requests a frame load from the pixel store, then walks
// row/column addresses and streams captured pixels over valid/ready with blanking.
module osd_frame_scanner #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 512,
  parameter int BPP          = 12,
  parameter int HBLANK       = 16,
  parameter int VBLANK       = 4,
  parameter int LOAD_TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      start,
  input  logic                      cont_mode,
  input  logic                      abort,
  output logic                      src_read,
  input  logic                      src_done,
  output logic [$clog2(HEIGHT):0]   src_row,
  output logic [$clog2(WIDTH):0]    src_col,
  input  logic [BPP-1:0]            src_data,
  output logic [BPP-1:0]            pix_data,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic                      pix_sof,
  output logic                      pix_eol,
  output logic                      busy,
  output logic                      load_err,
  output logic [15:0]               frame_cnt
);

  localparam int RW   = $clog2(HEIGHT) + 1;
  localparam int CW   = $clog2(WIDTH) + 1;
  localparam int TW   = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT);
  localparam int BMAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int BW   = (BMAX < 2) ? 1 : $clog2(BMAX);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VBLANK
  } state_t;

  state_t          state_reg, state_next;
  logic [RW-1:0]   row_reg, row_next;
  logic [CW-1:0]   col_reg, col_next;
  logic [BPP-1:0]  data_reg, data_next;
  logic            valid_reg, valid_next;
  logic            sof_reg, sof_next;
  logic            eol_reg, eol_next;
  logic            read_reg, read_next;
  logic            err_reg, err_next;
  logic [15:0]     fcnt_reg, fcnt_next;
  logic [TW-1:0]   tmo_reg, tmo_next;
  logic [BW-1:0]   blank_reg, blank_next;
  logic            advance;
  logic            last_col;
  logic            last_row;
  logic            frame_done;

  assign advance  = !valid_reg || pix_ready;
  assign last_col = (col_reg == CW'(WIDTH - 1));
  assign last_row = (row_reg == RW'(HEIGHT - 1));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg <= ST_IDLE;
      row_reg   <= '0;
      col_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      sof_reg   <= 1'b0;
      eol_reg   <= 1'b0;
      read_reg  <= 1'b0;
      err_reg   <= 1'b0;
      fcnt_reg  <= '0;
      tmo_reg   <= '0;
      blank_reg <= '0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      sof_reg   <= sof_next;
      eol_reg   <= eol_next;
      read_reg  <= read_next;
      err_reg   <= err_next;
      fcnt_reg  <= fcnt_next;
      tmo_reg   <= tmo_next;
      blank_reg <= blank_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    sof_next   = sof_reg;
    eol_next   = eol_reg;
    read_next  = 1'b0;
    err_next   = err_reg;
    fcnt_next  = fcnt_reg;
    tmo_next   = tmo_reg;
    blank_next = blank_reg;
    frame_done = 1'b0;

    if (abort) begin
      state_next = ST_IDLE;
      row_next   = '0;
      col_next   = '0;
      valid_next = 1'b0;
      sof_next   = 1'b0;
      eol_next   = 1'b0;
      tmo_next   = '0;
      blank_next = '0;
    end else begin
      // A pending pixel drains in any state; ACTIVE captures override this below.
      if (valid_reg && pix_ready) begin
        valid_next = 1'b0;
        sof_next   = 1'b0;
        eol_next   = 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_next = ST_LOAD;
            err_next   = 1'b0;
            read_next  = 1'b1;
            tmo_next   = '0;
          end
        end
        ST_LOAD: begin
          if (src_done) begin
            state_next = ST_ACTIVE;
            row_next   = '0;
            col_next   = '0;
          end else if (tmo_reg == TW'(LOAD_TIMEOUT - 1)) begin
            err_next   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            tmo_next = tmo_reg + TW'(1);
          end
        end
        ST_ACTIVE: begin
          if (advance) begin
            data_next  = src_data;
            valid_next = 1'b1;
            sof_next   = (row_reg == '0) && (col_reg == '0);
            eol_next   = last_col;
            if (!last_col) begin
              col_next = col_reg + CW'(1);
            end else begin
              col_next   = '0;
              blank_next = '0;
              if (!last_row) begin
                if (HBLANK == 0) row_next = row_reg + RW'(1);
                else             state_next = ST_HBLANK;
              end else if (VBLANK == 0) begin
                frame_done = 1'b1;
              end else begin
                state_next = ST_VBLANK;
              end
            end
          end
        end
        ST_HBLANK: begin
          if (blank_reg == BW'(HBLANK - 1)) begin
            row_next   = row_reg + RW'(1);
            state_next = ST_ACTIVE;
          end else begin
            blank_next = blank_reg + BW'(1);
          end
        end
        ST_VBLANK: begin
          if (blank_reg == BW'(VBLANK - 1)) frame_done = 1'b1;
          else                              blank_next = blank_reg + BW'(1);
        end
        default: state_next = ST_IDLE;
      endcase

      // cont_mode is only looked at here, i.e. at the very end of the frame.
      if (frame_done) begin
        fcnt_next = fcnt_reg + 16'd1;
        row_next  = '0;
        if (cont_mode) begin
          state_next = ST_LOAD;
          read_next  = 1'b1;
          tmo_next   = '0;
        end else begin
          state_next = ST_IDLE;
        end
      end
    end
  end

  assign src_read  = read_reg;
  assign src_row   = row_reg;
  assign src_col   = col_reg;
  assign pix_data  = data_reg;
  assign pix_valid = valid_reg;
  assign pix_sof   = sof_reg;
  assign pix_eol   = eol_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign load_err  = err_reg;
  assign frame_cnt = fcnt_reg;

endmodule

// File: tb/tb_osd_frame_scanner.sv
// Bench for osd_frame_scanner: table of frame scenarios (fixed and random backpressure)
// checked against a raster-order pixel model, plus timeout, abort and async-reset sequences.
module tb_osd_frame_scanner;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int HB  = 2;
  localparam int VB  = 3;
  localparam int LT  = 8;
  localparam int BPP = 12;

  logic        clk = 1'b0;
  logic        rstb, start, cont_mode, abort;
  logic        src_read, src_done;
  logic [2:0]  src_row, src_col;
  logic [11:0] src_data, pix_data;
  logic        pix_valid, pix_ready, pix_sof, pix_eol, busy, load_err;
  logic [15:0] frame_cnt;

  osd_frame_scanner #(
    .WIDTH(W), .HEIGHT(H), .BPP(BPP), .HBLANK(HB), .VBLANK(VB), .LOAD_TIMEOUT(LT)
  ) dut (
    .clk(clk), .rstb(rstb), .start(start), .cont_mode(cont_mode), .abort(abort),
    .src_read(src_read), .src_done(src_done), .src_row(src_row), .src_col(src_col),
    .src_data(src_data), .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .busy(busy), .load_err(load_err),
    .frame_cnt(frame_cnt)
  );

  // Frame source: pixel value is row*16+col.
  assign src_data = 12'(src_row) * 12'd16 + 12'(src_col);

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] data;
    logic        sof;
    logic        eol;
    int          cyc;
  } pix_t;

  typedef struct {
    int ready_mode;   // 0: always ready, 1: 1,0,0 pattern, 2: random
    int dly;          // src_done delay after src_read (0 = same cycle)
    bit cont;
    int exp_pixels;
    int exp_fc_delta;
  } vec_t;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   ready_mode = 0;
  int   done_dly = 3;
  bit   resp_en = 1'b1;
  bit   stall_chk = 1'b0;
  int   exp_fc = 0;
  pix_t got_q[$];
  int   sr_q[$];

  logic        prev_stall = 1'b0;
  logic [11:0] prev_data = '0;
  logic        prev_sof = 1'b0, prev_eol = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // src_done responder
  initial begin
    int cd = 0;
    src_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      src_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) src_done = 1'b1;
      end
      if (src_read === 1'b1 && resp_en) begin
        if (done_dly == 0) src_done = 1'b1;
        else               cd = done_dly;
      end
    end
  end

  // pix_ready driver
  initial begin
    int phase = 0;
    pix_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1: begin pix_ready = (phase == 0); phase = (phase + 1) % 3; end
        2: pix_ready = ($urandom_range(0, 99) < 60);
        default: pix_ready = 1'b1;
      endcase
    end
  end

  // Stream monitor, sampled mid-cycle.
  always @(negedge clk) begin
    pix_t p;
    if (rstb === 1'b1 && pix_valid === 1'b1 && pix_ready === 1'b1) begin
      p.data = pix_data; p.sof = pix_sof; p.eol = pix_eol; p.cyc = cyc;
      got_q.push_back(p);
    end
    if (rstb === 1'b1 && src_read === 1'b1) sr_q.push_back(cyc);
    if (stall_chk && prev_stall) begin
      n_cmp++;
      if (!(pix_valid === 1'b1 && pix_data === prev_data && pix_sof === prev_sof && pix_eol === prev_eol)) begin
        n_fail++;
        $display("FAIL stall_hold: got v=%0b d=0x%0h sof=%0b eol=%0b required v=1 d=0x%0h sof=%0b eol=%0b",
                 pix_valid, pix_data, pix_sof, pix_eol, prev_data, prev_sof, prev_eol);
      end
    end
    prev_stall = (rstb === 1'b1) && (pix_valid === 1'b1) && (pix_ready === 1'b0);
    prev_data  = pix_data;
    prev_sof   = pix_sof;
    prev_eol   = pix_eol;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_src_read"}, src_read, 0);
    chk({tag, "_src_row"}, src_row, 0);
    chk({tag, "_src_col"}, src_col, 0);
    chk({tag, "_pix_data"}, pix_data, 0);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_pix_sof"}, pix_sof, 0);
    chk({tag, "_pix_eol"}, pix_eol, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_load_err"}, load_err, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_scenario(input vec_t v, input int idx);
    pix_t exp_q[$];
    pix_t e;
    int   n;
    int   m;
    got_q.delete();
    sr_q.delete();
    ready_mode = v.ready_mode;
    done_dly   = v.dly;
    stall_chk  = 1'b1;
    @(posedge clk); #1; start = 1'b1; cont_mode = v.cont;
    @(posedge clk); #1; start = 1'b0;
    if (v.cont) begin
      n = 0;
      while (frame_cnt !== 16'(exp_fc + 1) && n < 3000) begin @(negedge clk); n++; end
      @(posedge clk); #1 cont_mode = 1'b0;
    end
    n = 0;
    while (!(busy === 1'b0 && pix_valid === 1'b0) && n < 3000) begin @(negedge clk); n++; end
    chk($sformatf("v%0d_finished_in_time", idx), 32'(n < 3000), 1);
    stall_chk = 1'b0;

    exp_fc += v.exp_fc_delta;
    chk($sformatf("v%0d_frame_cnt", idx), frame_cnt, 32'(16'(exp_fc)));
    chk($sformatf("v%0d_busy", idx), busy, 0);

    // Reference: every frame is the raster walk of the whole image.
    for (int f = 0; f < v.exp_fc_delta; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          e.data = 12'(r * 16 + c); e.sof = (r == 0 && c == 0); e.eol = (c == W - 1); e.cyc = 0;
          exp_q.push_back(e);
        end
    chk($sformatf("v%0d_pixel_count", idx), got_q.size(), v.exp_pixels);
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      chk($sformatf("v%0d_pix%0d{sof,eol,data}", idx, i),
          {got_q[i].sof, got_q[i].eol, got_q[i].data}, {exp_q[i].sof, exp_q[i].eol, exp_q[i].data});

    if (v.ready_mode == 0 && got_q.size() == v.exp_pixels) begin
      for (int i = 0; i + 1 < got_q.size(); i++) begin
        if (!got_q[i].eol)
          chk($sformatf("v%0d_pix_spacing%0d", idx, i), got_q[i+1].cyc - got_q[i].cyc, 1);
        else if (!got_q[i+1].sof)
          chk($sformatf("v%0d_line_gap%0d", idx, i), got_q[i+1].cyc - got_q[i].cyc, HB + 1);
      end
      if (v.cont) begin
        chk($sformatf("v%0d_src_read_pulses", idx), sr_q.size(), 2);
        if (sr_q.size() >= 2)
          chk($sformatf("v%0d_reload_delay", idx), sr_q[1] - got_q[W*H-1].cyc, VB);
      end
    end
  endtask

  vec_t vecs[6];

  initial begin
    bit found;
    vecs[0] = '{0, 3, 1'b0, 12, 1};   // single frame, always ready
    vecs[1] = '{1, 3, 1'b0, 12, 1};   // backpressure 1,0,0
    vecs[2] = '{0, 3, 1'b1, 24, 2};   // continuous, two frames
    vecs[3] = '{0, 0, 1'b0, 12, 1};   // src_done together with src_read
    vecs[4] = '{2, 3, 1'b0, 12, 1};   // random ready
    vecs[5] = '{2, 5, 1'b1, 24, 2};   // random ready, continuous

    rstb = 1'b1; start = 1'b0; cont_mode = 1'b0; abort = 1'b0;
    #2 rstb = 1'b0;
    #2 check_reset_values("reset0");
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_scenario(vecs[i], i);
      $display("scenario %0d: ready_mode=%0d dly=%0d cont=%0b pixels=%0d frame_cnt=%0d",
               i, vecs[i].ready_mode, vecs[i].dly, vecs[i].cont, got_q.size(), frame_cnt);
    end

    // Load timeout: LOAD lasts exactly LT cycles.
    ready_mode = 0;
    resp_en = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (LT - 1) @(posedge clk);
    @(negedge clk);
    chk("tmo_last_load_cycle_err", load_err, 0);
    chk("tmo_last_load_cycle_busy", busy, 1);
    @(negedge clk);
    chk("tmo_load_err_set", load_err, 1);
    chk("tmo_back_to_idle", busy, 0);
    pulse_start();
    @(negedge clk);
    chk("tmo_start_clears_err", load_err, 0);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("tmo_abort_idle", busy, 0);
    resp_en = 1'b1;
    $display("timeout sequence: load_err cleared by start, frame_cnt=%0d", frame_cnt);

    // Abort right after pixel 0x11.
    got_q.delete();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (pix_valid === 1'b1 && pix_ready === 1'b1 && pix_data === 12'h011) found = 1'b1;
    end
    chk("abort_saw_0x11", 32'(found), 1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_pix_valid", pix_valid, 0);
    chk("abort_pix_sof", pix_sof, 0);
    chk("abort_pix_eol", pix_eol, 0);
    chk("abort_src_row", src_row, 0);
    chk("abort_src_col", src_col, 0);
    chk("abort_busy", busy, 0);
    chk("abort_frame_cnt", frame_cnt, 32'(16'(exp_fc)));
    $display("abort sequence: frame_cnt=%0d", frame_cnt);
    run_scenario(vecs[0], 6);
    $display("replay after abort: pixels=%0d frame_cnt=%0d", got_q.size(), frame_cnt);

    // Start while busy is ignored, then asynchronous reset mid-frame.
    ready_mode = 0;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (pix_valid === 1'b1 && pix_data === 12'h010) found = 1'b1;
    end
    chk("rst_saw_0x10", 32'(found), 1);
    sr_q.delete();
    pulse_start();
    repeat (4) @(negedge clk);
    chk("busy_start_ignored_src_read", sr_q.size(), 0);
    chk("busy_start_ignored_busy", busy, 1);
    @(posedge clk); #3 rstb = 1'b0;
    #1 check_reset_values("async_rst");
    exp_fc = 0;
    @(posedge clk); #1 rstb = 1'b1;
    $display("async reset sequence: frame_cnt=%0d busy=%0b", frame_cnt, busy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/osd_frame_scanner.md
Name: osd_frame_scanner

Overview:
- Raster-scan controller that sequences the frame-source pixel store for the OSD pipeline.
- Requests a frame load, waits for load completion, then walks row/column addresses in raster order.
- Captures the addressed pixel and presents it as a valid/ready pixel stream with start-of-frame and end-of-line markers.
- Inserts programmable horizontal and vertical blanking; supports single-shot and continuous frame modes.

Parameters:
- WIDTH, 640, active pixels per line
- HEIGHT, 512, active lines per frame
- BPP, 12, bits per pixel
- HBLANK, 16, idle cycles after each line (0 allowed)
- VBLANK, 4, idle cycles after the last line (0 allowed)
- LOAD_TIMEOUT, 1024, maximum cycles in LOAD waiting for src_done

Ports:
- clk  in  1  single clock
- rstb  in  1  reset, asynchronous assert, active-low
- start  in  1  one-cycle pulse; begins a frame when the block is idle
- cont_mode  in  1  1 = start the next frame automatically after VBLANK; sampled at the end of VBLANK
- abort  in  1  synchronous abort to IDLE
- src_read  out  1  one-cycle load request to the frame source
- src_done  in  1  one-cycle pulse; the frame source has finished loading
- src_row  out  $clog2(HEIGHT)+1  row address to the source
- src_col  out  $clog2(WIDTH)+1  column address to the source
- src_data  in  BPP  pixel at (src_row, src_col); combinational from the address
- pix_data  out  BPP  output pixel
- pix_valid  out  1  pix_data is valid
- pix_ready  in  1  downstream accept
- pix_sof  out  1  qualifies pix_data as pixel (0,0)
- pix_eol  out  1  qualifies pix_data as the last pixel of a line
- busy  out  1  state is not IDLE
- load_err  out  1  sticky; set on LOAD timeout; cleared by reset or by start
- frame_cnt  out  16  count of completed frames, wraps at 2^16

Behaviour:
- Reset values: src_read=0, src_row=0, src_col=0, pix_data=0, pix_valid=0, pix_sof=0, pix_eol=0, busy=0, load_err=0, frame_cnt=0; state=IDLE.
- States: IDLE, LOAD, ACTIVE, HBLANK, VBLANK.
- IDLE:
  - start=1 -> LOAD; clear load_err; src_read=1 for exactly the first cycle in LOAD.
  - start while busy is ignored.
- LOAD:
  - Timeout counter clears on entry.
  - src_done=1 -> ACTIVE, with row=0 and col=0.
  - LOAD_TIMEOUT cycles elapsed without src_done -> load_err=1, IDLE.
  - src_done on the same cycle as the src_read pulse is accepted.
- ACTIVE, capture rule:
  - Advance when (!pix_valid || pix_ready).
  - On advance: pix_data<=src_data; pix_valid<=1; pix_sof<=(row==0 && col==0); pix_eol<=(col==WIDTH-1).
  - col increments on advance.
  - Latency: the first pixel is valid on the cycle after entering ACTIVE.
  - Stall: while pix_valid && !pix_ready, address and pix_* hold stable.
- Line end:
  - Advance with col==WIDTH-1 -> col<=0, then HBLANK if row<HEIGHT-1, else VBLANK.
  - HBLANK=0 skips HBLANK: row increments and the state stays ACTIVE.
  - Leaving HBLANK: row increments, state returns to ACTIVE.
- HBLANK/VBLANK:
  - Count exactly HBLANK / VBLANK clock cycles regardless of pix_ready.
  - No captures during blanking.
  - A pending pix_valid is still handed off and cleared when pix_ready=1.
  - The next line may begin while the last pixel is still pending; the capture rule governs this.
- Frame end:
  - Leaving VBLANK (or directly after the last pixel when VBLANK=0): frame_cnt++, row<=0.
  - If cont_mode=1, go to LOAD with a new src_read pulse; otherwise go to IDLE.
- Output stream in IDLE: pix_valid clears on the first pix_ready=1 after entering IDLE.
- abort:
  - In any state -> IDLE next cycle.
  - pix_valid, pix_sof and pix_eol clear; addresses reset to 0.
  - frame_cnt is not incremented.
  - abort has priority over start, src_done and all transitions.
- Reset mid-frame: immediate return to reset values; no residual src_read.
- Widths: row/col counters use the port widths; they never exceed HEIGHT-1 / WIDTH-1.

Test Plan (bench uses WIDTH=4, HEIGHT=3, HBLANK=2, VBLANK=3, LOAD_TIMEOUT=8, source model data=row*16+col):
- Single frame, pix_ready=1, start pulse, src_done 3 cycles after src_read:
  - Exactly 12 pixels 0x00..0x03, 0x10..0x13, 0x20..0x23.
  - pix_sof only on 0x00; pix_eol on 0x03, 0x13, 0x23.
  - 2 gap cycles between lines; frame_cnt=1; busy=0 after VBLANK.
- Backpressure, pix_ready toggling 1,0,0,1,...:
  - No pixel is dropped or duplicated.
  - pix_data, pix_sof and pix_eol stay stable while stalled.
  - The sequence matches the previous scenario.
- Continuous mode, cont_mode=1:
  - A second src_read pulse comes 3 cycles after the last line's blanking starts.
  - Two frames are output; frame_cnt=2 after cont_mode drops.
- Load timeout, src_done never asserted:
  - load_err=1 after 8 LOAD cycles; state returns to IDLE.
  - The next start clears load_err.
- Abort mid-line, assert abort after pixel 0x11:
  - pix_valid=0 next cycle; src_row=0, src_col=0; frame_cnt unchanged.
  - A new start replays from 0x00.
- Async reset during ACTIVE:
  - All outputs take their reset values without a clock edge.
  - start pulses while busy are ignored.
